// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types, scan-code constants and the set-2 to ASCII
// translation used by the PS/2 character writer.
//   frame_state_e  : receive frame FSM states
//   SC_*           : scan codes with special meaning
//   scan_to_ascii  : returns {valid, ascii}; valid=0 for unmapped codes
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_e;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_SPACE = 8'h29;

    function automatic logic [8:0] scan_to_ascii(input logic [7:0] code);
        logic [8:0] r;
        r = 9'h000;
        case (code)
            8'h1C: r = {1'b1, 8'h41}; // A
            8'h32: r = {1'b1, 8'h42};
            8'h21: r = {1'b1, 8'h43};
            8'h23: r = {1'b1, 8'h44};
            8'h24: r = {1'b1, 8'h45};
            8'h2B: r = {1'b1, 8'h46};
            8'h34: r = {1'b1, 8'h47};
            8'h33: r = {1'b1, 8'h48};
            8'h43: r = {1'b1, 8'h49};
            8'h3B: r = {1'b1, 8'h4A};
            8'h42: r = {1'b1, 8'h4B};
            8'h4B: r = {1'b1, 8'h4C};
            8'h3A: r = {1'b1, 8'h4D};
            8'h31: r = {1'b1, 8'h4E};
            8'h44: r = {1'b1, 8'h4F};
            8'h4D: r = {1'b1, 8'h50};
            8'h15: r = {1'b1, 8'h51};
            8'h2D: r = {1'b1, 8'h52};
            8'h1B: r = {1'b1, 8'h53};
            8'h2C: r = {1'b1, 8'h54};
            8'h3C: r = {1'b1, 8'h55};
            8'h2A: r = {1'b1, 8'h56};
            8'h1D: r = {1'b1, 8'h57};
            8'h22: r = {1'b1, 8'h58};
            8'h35: r = {1'b1, 8'h59};
            8'h1A: r = {1'b1, 8'h5A}; // Z
            8'h45: r = {1'b1, 8'h30}; // 0
            8'h16: r = {1'b1, 8'h31};
            8'h1E: r = {1'b1, 8'h32};
            8'h26: r = {1'b1, 8'h33};
            8'h25: r = {1'b1, 8'h34};
            8'h2E: r = {1'b1, 8'h35};
            8'h36: r = {1'b1, 8'h36};
            8'h3D: r = {1'b1, 8'h37};
            8'h3E: r = {1'b1, 8'h38};
            8'h46: r = {1'b1, 8'h39}; // 9
            SC_SPACE: r = {1'b1, 8'h20};
            default: r = 9'h000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 receive front end. Synchronizes and filters the raw
// keyboard lines, samples data on filtered ps2_clk falling edges and
// assembles 11-bit frames into bytes.
//   clk, reset            : system clock, synchronous active-high reset
//   ps2_clk_i, ps2_data_i : raw asynchronous keyboard lines
//   rx_byte_o             : last received byte (stable after byte_valid_o)
//   byte_valid_o          : one-cycle pulse, cycle after a good stop bit
//   frame_err_o           : one-cycle pulse on start/parity/stop error or timeout
//
// state  | meaning
// IDLE   | waiting for a start bit
// DATA   | shifting in 8 data bits, LSB first
// PARITY | checking odd parity over data+parity
// STOP   | checking stop bit, delivering byte or error
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILT_LEN = 4,
    parameter int TIMEOUT  = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] rx_byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic          clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          sample;

    frame_state_e  state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          timeout;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;

    // Lines idle high, so synchronizers and filter reset to 1 to avoid a
    // spurious falling edge right after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_q   <= 1'b1;
            clk_sync_q   <= 1'b1;
            dat_meta_q   <= 1'b1;
            dat_sync_q   <= 1'b1;
            filt_q       <= 1'b1;
            fcnt_q       <= FW'(FILT_LEN - 1);
            state_q      <= IDLE;
            bitcnt_q     <= '0;
            shreg_q      <= '0;
            par_ok_q     <= 1'b0;
            tcnt_q       <= TW'(TIMEOUT - 1);
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_meta_q   <= ps2_clk_i;
            clk_sync_q   <= clk_meta_q;
            dat_meta_q   <= ps2_data_i;
            dat_sync_q   <= dat_meta_q;
            filt_q       <= filt_d;
            fcnt_q       <= fcnt_d;
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shreg_q      <= shreg_d;
            par_ok_q     <= par_ok_d;
            tcnt_q       <= tcnt_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Filter: down-counter reloads while the input agrees with the filtered
    // level; the level flips on the FILT_LEN-th consecutive differing sample.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        if (clk_sync_q == filt_q) begin
            fcnt_d = FW'(FILT_LEN - 1);
        end else if (fcnt_q == '0) begin
            filt_d = clk_sync_q;
            fcnt_d = FW'(FILT_LEN - 1);
        end else begin
            fcnt_d = fcnt_q - FW'(1);
        end
    end

    assign sample  = filt_q & ~filt_d;
    assign timeout = (state_q != IDLE) && !sample && (tcnt_q == '0);

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shreg_d      = shreg_q;
        par_ok_d     = par_ok_q;
        tcnt_d       = tcnt_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (state_q == IDLE || sample) begin
            tcnt_d = TW'(TIMEOUT - 1);
        end else if (tcnt_q != '0) begin
            tcnt_d = tcnt_q - TW'(1);
        end

        if (sample) begin
            case (state_q)
                IDLE: begin
                    if (!dat_sync_q) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                DATA: begin
                    shreg_d  = {dat_sync_q, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_ok_d = ^{shreg_q, dat_sync_q};
                    state_d  = STOP;
                end
                STOP: begin
                    if (dat_sync_q && par_ok_q) byte_valid_d = 1'b1;
                    else                        frame_err_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
        end
    end

    assign rx_byte_o    = shreg_q;
    assign byte_valid_o = byte_valid_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ps2_char_writer.sv
// ps2_char_writer: fills the text character buffer from a PS/2 keyboard.
// Decodes make codes (ignoring break and extended sequences) and issues
// one-cycle writes at a hardware cursor; handles Backspace and Enter.
//   clk, reset          : system clock, synchronous active-high reset
//   ps2_clk, ps2_data   : raw asynchronous keyboard lines
//   we, waddr, wdata    : char buffer write port
//   cursor              : current cursor position
//   frame_err           : one-cycle pulse on a receive error or timeout
module ps2_char_writer
    import ps2_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int LINE_W   = 16,
    parameter int FILT_LEN = 4,
    parameter int TIMEOUT  = 5000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [7:0]        wdata,
    output logic [ADDR_W-1:0] cursor,
    output logic              frame_err
);

    logic [7:0]        rx_byte;
    logic              byte_valid;

    logic              brk_q, brk_d, ext_q, ext_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [ADDR_W-1:0] cursor_q, cursor_d;
    logic              cur_upd_q, cur_upd_d;
    logic [ADDR_W-1:0] cur_nxt_q, cur_nxt_d;
    logic [8:0]        asc;

    ps2_rx_frame #(
        .FILT_LEN (FILT_LEN),
        .TIMEOUT  (TIMEOUT)
    ) u_rx (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk_i    (ps2_clk),
        .ps2_data_i   (ps2_data),
        .rx_byte_o    (rx_byte),
        .byte_valid_o (byte_valid),
        .frame_err_o  (frame_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            cursor_q  <= '0;
            cur_upd_q <= 1'b0;
            cur_nxt_q <= '0;
        end else begin
            brk_q     <= brk_d;
            ext_q     <= ext_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            cursor_q  <= cursor_d;
            cur_upd_q <= cur_upd_d;
            cur_nxt_q <= cur_nxt_d;
        end
    end

    assign asc = scan_to_ascii(rx_byte);

    // Translation happens the cycle after byte_valid; the write strobe is
    // registered from it, and the cursor moves one cycle after the strobe.
    always_comb begin
        brk_d     = brk_q;
        ext_d     = ext_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        cur_upd_d = 1'b0;
        cur_nxt_d = cur_nxt_q;
        cursor_d  = cur_upd_q ? cur_nxt_q : cursor_q;

        if (byte_valid) begin
            if (rx_byte == SC_BREAK) begin
                brk_d = 1'b1;
            end else if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (brk_q || ext_q) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else if (rx_byte == SC_BKSP) begin
                we_d      = 1'b1;
                waddr_d   = cursor_q - ADDR_W'(1);
                wdata_d   = 8'h20;
                cur_upd_d = 1'b1;
                cur_nxt_d = cursor_q - ADDR_W'(1);
            end else if (rx_byte == SC_ENTER) begin
                cur_upd_d = 1'b1;
                cur_nxt_d = (cursor_q | ADDR_W'(LINE_W - 1)) + ADDR_W'(1);
            end else if (asc[8]) begin
                we_d      = 1'b1;
                waddr_d   = cursor_q;
                wdata_d   = asc[7:0];
                cur_upd_d = 1'b1;
                cur_nxt_d = cursor_q + ADDR_W'(1);
            end
        end
    end

    assign we     = we_q;
    assign waddr  = waddr_q;
    assign wdata  = wdata_q;
    assign cursor = cursor_q;

endmodule

// File: doc/ps2_char_writer.md
Name: ps2_char_writer

Overview:
- Input-side counterpart to the VGA text path. The VGA block reads the 256-entry character buffer and draws it; this block fills that same buffer from a PS/2 keyboard.
- Receives PS/2 set-2 scan codes, decodes make codes to ASCII and issues one-cycle writes into the character buffer write port at a hardware cursor.
- Runs on the system pixel/CPU clock, clk3, alongside Memory_Management.

Parameters:
- ADDR_W, 8, char buffer address width; depth = 2**ADDR_W.
- LINE_W, 16, characters per text line; Enter advances the cursor to the next multiple of LINE_W. Must be a power of two.
- FILT_LEN, 4, consecutive equal samples needed to accept a ps2_clk level.
- TIMEOUT, 5000, clk cycles without a ps2_clk falling edge before an in-progress frame is aborted.

Ports:
- clk  in  1  system clock (clk3 domain).
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw keyboard clock, asynchronous.
- ps2_data  in  1  raw keyboard data, asynchronous.
- we  out  1  one-cycle write strobe to the char buffer.
- waddr  out  ADDR_W  write address.
- wdata  out  8  ASCII byte to write.
- cursor  out  ADDR_W  current cursor position.
- frame_err  out  1  one-cycle pulse on a start, parity or stop error, or a timeout.

Behaviour:
- Reset: we=0, waddr=0, wdata=0, cursor=0, frame_err=0. FSM goes to IDLE; break and extended flags clear; filter and timeout counters clear. Reset mid-frame discards the partial frame.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - The synchronized ps2_clk feeds a level filter that changes state only after FILT_LEN equal consecutive samples.
  - A falling edge of the filtered clock is the bit-sample event. Data is taken from the synchronized ps2_data on that cycle.
- Frame FSM, one transition per sample event:
  - IDLE: data=0 goes to DATA with bit count 0; data=1 is a start error, so pulse frame_err and stay in IDLE.
  - DATA: shift in 8 bits, LSB first; after the 8th bit go to PARITY.
  - PARITY: odd parity over data+parity is required; go to STOP in either case and record the parity result.
  - STOP: data=1 with good parity produces byte_valid; otherwise pulse frame_err. Both cases return to IDLE.
  - In any non-IDLE state, TIMEOUT cycles with no sample event: pulse frame_err, go to IDLE, discard the byte.
- Code handling, in the cycle after byte_valid:
  - 0xF0 sets the break flag.
  - 0xE0 sets the extended flag.
  - For any other code: if the break or extended flag is set, discard the code and clear both flags. Otherwise translate it.
- Translation:
  - Letters 0x1C,0x32,0x21,…,0x1A map to 'A'..'Z' (0x41..0x5A), uppercase only.
  - Digit codes 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 map to '0'..'9'.
  - 0x29 maps to 0x20 (space).
  - Special codes: 0x66 is Backspace, 0x5A is Enter.
  - Every other code is ignored, with no write and no cursor change.
- Write timing: the stop bit is sampled in cycle N, translation happens in N+1, and we=1 in N+2 with waddr and wdata valid in that same cycle.
  - Printable character: waddr=cursor, wdata=ascii; cursor increments in N+3, wrapping 2**ADDR_W-1 to 0.
  - Backspace: waddr=cursor-1 (0 wraps to 2**ADDR_W-1), wdata=0x20; cursor takes that value.
  - Enter: no write; cursor = (cursor | (LINE_W-1)) + 1 modulo depth. If cursor is already on a line boundary it still advances one full line.
- At most one write per received byte. Back-to-back keyboard bytes cannot collide, because a frame spans ≥11 sample events.

Decomposition:
- Package ps2_pkg holds:
  - the frame state enum (IDLE, DATA, PARITY, STOP);
  - constants SC_BREAK=0xF0, SC_EXT=0xE0, SC_BKSP=0x66, SC_ENTER=0x5A, SC_SPACE=0x29;
  - the function scan_to_ascii(code) returning {valid, ascii}.
- One sub-module, ps2_rx_frame, contains the synchronizers, filter, timeout counter and frame FSM, and outputs byte, byte_valid and frame_err.
- The top level holds the flags, the cursor and the write registers.

Test Plan:
- Reset, then frame 0x1C with correct parity → we pulse at N+2 with waddr=0x00, wdata=0x41; cursor=0x01 one cycle later.
- Send F0 then 1C → no we pulse; cursor unchanged; a following 0x16 writes 0x31.
- Send 0x1C with wrong parity bit → frame_err pulses once; no write. Repeat with stop bit=0 → same result.
- 256 consecutive 0x29 → the last write has waddr=0xFF; cursor=0x00; the next write goes to waddr=0x00.
- At cursor=0, send 0x66 → write at waddr=0xFF, wdata=0x20, cursor=0xFF. At cursor=5, send 0x5A → no write, cursor=16. At cursor=16, send 0x5A → cursor=32.
- Stop ps2_clk after 4 data bits for TIMEOUT+10 cycles → frame_err pulses; the next full frame decodes correctly. Assert reset mid-frame → all outputs return to 0 and the next frame decodes correctly.
